// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// mem_arbiter : two-master req/ready arbiter for the shared 256-byte memory,
//               with round-robin or fixed priority and a stall watchdog.
// Revision    : 1.0
// ============================================================================
module mem_arbiter #(
  parameter int AW         = 8,
  parameter int DW         = 8,
  parameter int TIMEOUT    = 16,
  parameter int FIXED_PRIO = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic [AW-1:0] m0_addr,
  input  logic          m0_we,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_ready,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic [AW-1:0] m1_addr,
  input  logic          m1_we,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_ready,
  output logic [DW-1:0] m1_rdata,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ready,
  input  logic [DW-1:0] mem_rdata,
  output logic [1:0]    grant,
  output logic          err
);

  localparam int                CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       grant_q, grant_d;
  logic             last_grant_q, last_grant_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
  logic [DW-1:0]    m0_rdata_q, m0_rdata_d;
  logic [DW-1:0]    m1_rdata_q, m1_rdata_d;

  logic             w_tie_pick_m1;
  logic             w_pick_m1;
  logic             w_in_access;
  logic             w_in_done;

  generate
    if (FIXED_PRIO != 0) begin : g_fixed_prio
      assign w_tie_pick_m1 = 1'b0;
    end else begin : g_round_robin
      assign w_tie_pick_m1 = ~last_grant_q;
    end
  endgenerate

  assign w_pick_m1 = (m0_req && m1_req) ? w_tie_pick_m1 : m1_req;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    timeout_d    = timeout_q;
    m0_rdata_d   = m0_rdata_q;
    m1_rdata_d   = m1_rdata_q;
    case (state_q)
      ST_IDLE: begin
        grant_d   = 2'b00;
        timeout_d = 1'b0;
        if (m0_req || m1_req) begin
          grant_d      = w_pick_m1 ? 2'b10 : 2'b01;
          last_grant_d = w_pick_m1;
          cnt_d        = '0;
          state_d      = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        // A stalled memory completes with all-ones data so the master never hangs.
        if (mem_ready || (cnt_q == CNT_LAST)) begin
          timeout_d = ~mem_ready;
          if (grant_q[1]) begin
            m1_rdata_d = mem_ready ? mem_rdata : '1;
          end else begin
            m0_rdata_d = mem_ready ? mem_rdata : '1;
          end
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        grant_d   = 2'b00;
        timeout_d = 1'b0;
        state_d   = ST_IDLE;
      end
      default: begin
        grant_d   = 2'b00;
        timeout_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      grant_q      <= 2'b00;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      timeout_q    <= 1'b0;
      m0_rdata_q   <= '0;
      m1_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      timeout_q    <= timeout_d;
      m0_rdata_q   <= m0_rdata_d;
      m1_rdata_q   <= m1_rdata_d;
    end
  end

  assign w_in_access = (state_q == ST_ACCESS);
  assign w_in_done   = (state_q == ST_DONE);

  assign mem_req   = w_in_access;
  assign mem_addr  = w_in_access ? (grant_q[1] ? m1_addr  : m0_addr)  : '0;
  assign mem_we    = w_in_access ? (grant_q[1] ? m1_we    : m0_we)    : 1'b0;
  assign mem_wdata = w_in_access ? (grant_q[1] ? m1_wdata : m0_wdata) : '0;

  assign m0_ready = w_in_done && grant_q[0];
  assign m1_ready = w_in_done && grant_q[1];
  assign err      = w_in_done && timeout_q;
  assign grant    = grant_q;
  assign m0_rdata = m0_rdata_q;
  assign m1_rdata = m1_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_mem_arbiter : round-robin and fixed-priority arbiters side by side,
//                  driven by directed transactions against a memory responder.
// Revision       : 1.0
// ============================================================================
module tb_mem_arbiter;

  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       m0_req, m1_req, m0_we, m1_we;
  logic [7:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  int         sel;
  logic       mem_en;

  // Only the selected instance (0 = round-robin, 1 = fixed) sees requests.
  logic [1:0] r0, r1;
  assign r0 = {m0_req & (sel == 1), m0_req & (sel == 0)};
  assign r1 = {m1_req & (sel == 1), m1_req & (sel == 0)};

  logic [1:0]      m0_ready_w, m1_ready_w, mem_req_w, mem_we_w, err_w;
  logic [1:0][7:0] m0_rdata_w, m1_rdata_w, mem_addr_w, mem_wdata_w;
  logic [1:0][1:0] grant_w;
  logic [1:0]      mem_ready_r;
  logic [1:0][7:0] mem_rdata_r;

  mem_arbiter #(.AW(8), .DW(8), .TIMEOUT(TIMEOUT), .FIXED_PRIO(0)) dut_rr (
    .clk(clk), .rst(rst),
    .m0_req(r0[0]), .m0_addr(m0_addr), .m0_we(m0_we), .m0_wdata(m0_wdata),
    .m0_ready(m0_ready_w[0]), .m0_rdata(m0_rdata_w[0]),
    .m1_req(r1[0]), .m1_addr(m1_addr), .m1_we(m1_we), .m1_wdata(m1_wdata),
    .m1_ready(m1_ready_w[0]), .m1_rdata(m1_rdata_w[0]),
    .mem_req(mem_req_w[0]), .mem_addr(mem_addr_w[0]), .mem_we(mem_we_w[0]),
    .mem_wdata(mem_wdata_w[0]), .mem_ready(mem_ready_r[0]), .mem_rdata(mem_rdata_r[0]),
    .grant(grant_w[0]), .err(err_w[0])
  );

  mem_arbiter #(.AW(8), .DW(8), .TIMEOUT(TIMEOUT), .FIXED_PRIO(1)) dut_fp (
    .clk(clk), .rst(rst),
    .m0_req(r0[1]), .m0_addr(m0_addr), .m0_we(m0_we), .m0_wdata(m0_wdata),
    .m0_ready(m0_ready_w[1]), .m0_rdata(m0_rdata_w[1]),
    .m1_req(r1[1]), .m1_addr(m1_addr), .m1_we(m1_we), .m1_wdata(m1_wdata),
    .m1_ready(m1_ready_w[1]), .m1_rdata(m1_rdata_w[1]),
    .mem_req(mem_req_w[1]), .mem_addr(mem_addr_w[1]), .mem_we(mem_we_w[1]),
    .mem_wdata(mem_wdata_w[1]), .mem_ready(mem_ready_r[1]), .mem_rdata(mem_rdata_r[1]),
    .grant(grant_w[1]), .err(err_w[1])
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory: answers one cycle after it first sees mem_req, unless stalled.
  logic [7:0] mem [2][256];
  int         age [2];

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      age[k] = mem_req_w[k] ? age[k] + 1 : 0;
      if (mem_req_w[k] && mem_en && age[k] == 2) begin
        if (mem_we_w[k]) mem[k][mem_addr_w[k]] = mem_wdata_w[k];
        mem_rdata_r[k] = mem[k][mem_addr_w[k]];
        mem_ready_r[k] = 1'b1;
      end else begin
        mem_rdata_r[k] = 8'($urandom);
        mem_ready_r[k] = 1'b0;
      end
    end
  end

  // Transaction-level model: owner (0 none, 1 port0, 2 port1), cycles waited,
  // completion flag, abort flag, last winner, and the returned data per port.
  int         own [2];
  int         wt  [2];
  int         lst [2];
  bit         dn  [2];
  bit         er  [2];
  logic [7:0] rd0 [2];
  logic [7:0] rd1 [2];

  task automatic store(input int k, input logic [7:0] d);
    if (own[k] == 1) rd0[k] = d;
    else             rd1[k] = d;
  endtask

  task automatic model_step(input int k);
    int w;
    if (rst) begin
      own[k] = 0; wt[k] = 0; dn[k] = 0; er[k] = 0; lst[k] = 1; rd0[k] = 0; rd1[k] = 0;
    end else if (dn[k]) begin
      dn[k] = 0; er[k] = 0; own[k] = 0;
    end else if (own[k] == 0) begin
      if (r0[k] || r1[k]) begin
        if (r0[k] && r1[k]) w = (k == 1) ? 0 : 1 - lst[k];
        else                w = r1[k] ? 1 : 0;
        own[k] = w + 1; lst[k] = w; wt[k] = 0;
      end
    end else if (mem_ready_r[k]) begin
      store(k, mem_rdata_r[k]); dn[k] = 1;
    end else if (wt[k] == TIMEOUT - 1) begin
      store(k, 8'hFF); dn[k] = 1; er[k] = 1;
    end else begin
      wt[k]++;
    end
  endtask

  task automatic compare(input int k);
    bit act;
    act = (own[k] != 0) && !dn[k];
    chk($sformatf("u%0d.grant", k), grant_w[k], (own[k] == 0) ? 0 : (1 << (own[k] - 1)));
    chk($sformatf("u%0d.mem_req", k), mem_req_w[k], act);
    chk($sformatf("u%0d.mem_addr", k), mem_addr_w[k], !act ? 0 : (own[k] == 1 ? m0_addr : m1_addr));
    chk($sformatf("u%0d.mem_we", k), mem_we_w[k], !act ? 0 : (own[k] == 1 ? m0_we : m1_we));
    chk($sformatf("u%0d.mem_wdata", k), mem_wdata_w[k], !act ? 0 : (own[k] == 1 ? m0_wdata : m1_wdata));
    chk($sformatf("u%0d.m0_ready", k), m0_ready_w[k], dn[k] && own[k] == 1);
    chk($sformatf("u%0d.m1_ready", k), m1_ready_w[k], dn[k] && own[k] == 2);
    chk($sformatf("u%0d.err", k), err_w[k], dn[k] && er[k]);
    chk($sformatf("u%0d.m0_rdata", k), m0_rdata_w[k], rd0[k]);
    chk($sformatf("u%0d.m1_rdata", k), m1_rdata_w[k], rd1[k]);
  endtask

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) model_step(k);
    #1;
    for (int k = 0; k < 2; k++) compare(k);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic run_txn(input int port, input bit we, input logic [7:0] addr, input logic [7:0] wd,
                         output int lat, output logic [7:0] a1, output bit we1,
                         output logic [7:0] wd1, output int stray);
    bit seen;
    seen = 0; lat = 0; stray = 0; a1 = 0; we1 = 0; wd1 = 0;
    tick();
    if (port == 0) begin m0_addr = addr; m0_we = we; m0_wdata = wd; m0_req = 1'b1; end
    else           begin m1_addr = addr; m1_we = we; m1_wdata = wd; m1_req = 1'b1; end
    for (int c = 0; c < 64 && !seen; c++) begin
      tick();
      lat++;
      if (lat == 1) begin a1 = mem_addr_w[sel]; we1 = mem_we_w[sel]; wd1 = mem_wdata_w[sel]; end
      if (port == 0 ? m1_ready_w[sel] : m0_ready_w[sel]) stray++;
      if (port == 0 ? m0_ready_w[sel] : m1_ready_w[sel]) seen = 1;
    end
    m0_req = 1'b0; m1_req = 1'b0;
    chk("txn_completed", seen, 1);
  endtask

  // Holds both requests; returns the order of completions as hex digits (1/2).
  task automatic contend(input int n_total, input int drop_m0_after, output int seq, output int n0, output int n1);
    int n;
    n = 0; seq = 0; n0 = 0; n1 = 0;
    tick();
    m0_addr = 8'h04; m0_we = 1'b0; m1_addr = 8'hE0; m1_we = 1'b0;
    m0_req = 1'b1; m1_req = 1'b1;
    for (int c = 0; c < 400 && n < n_total; c++) begin
      tick();
      if (m0_ready_w[sel]) begin seq = seq * 16 + 1; n0++; n++; end
      if (m1_ready_w[sel]) begin seq = seq * 16 + 2; n1++; n++; end
      if (n == drop_m0_after) m0_req = 1'b0;
    end
    m0_req = 1'b0; m1_req = 1'b0;
    chk("contend_count", n, n_total);
  endtask

  int         lat, stray, seq, n0, n1, acc, errs;
  logic [7:0] a1, wd1;
  bit         we1, got;

  initial begin
    rst = 1'b1; sel = 0; mem_en = 1'b1;
    m0_req = 0; m1_req = 0; m0_we = 0; m1_we = 0;
    m0_addr = 0; m1_addr = 0; m0_wdata = 0; m1_wdata = 0;
    for (int k = 0; k < 2; k++) begin
      age[k] = 0; mem_ready_r[k] = 0; mem_rdata_r[k] = 0;
      for (int a = 0; a < 256; a++) mem[k][a] = 8'(a);
      mem[k][4] = 8'h20;
    end
    repeat (3) tick();
    chk("reset_grant", grant_w[0], 0);
    chk("reset_mem_req", mem_req_w[0], 0);
    chk("reset_rdata", m0_rdata_w[0], 0);
    rst = 1'b0;

    // Single uncontended read
    run_txn(0, 1'b0, 8'h04, 8'h00, lat, a1, we1, wd1, stray);
    chk("t1_latency", lat, 3);
    chk("t1_mem_addr", a1, 8'h04);
    chk("t1_rdata", m0_rdata_w[0], 8'h20);
    chk("t1_grant_done", grant_w[0], 2'b01);
    tick();
    chk("t1_grant_idle", grant_w[0], 2'b00);
    chk("t1_ready_pulse", m0_ready_w[0], 0);

    // Port 1 write then read-back
    run_txn(1, 1'b1, 8'hE0, 8'h55, lat, a1, we1, wd1, stray);
    chk("t2_mem_we", we1, 1);
    chk("t2_mem_wdata", wd1, 8'h55);
    chk("t2_mem_addr", a1, 8'hE0);
    chk("t2_no_m0_ready_wr", stray, 0);
    run_txn(1, 1'b0, 8'hE0, 8'h00, lat, a1, we1, wd1, stray);
    chk("t2_readback", m1_rdata_w[0], 8'h55);
    chk("t2_no_m0_ready_rd", stray, 0);

    // Round-robin contention
    contend(6, 99, seq, n0, n1);
    chk("rr_sequence", seq, 32'h121212);
    chk("rr_m0_count", n0, 3);
    chk("rr_m1_count", n1, 3);

    // Fixed priority: port 0 wins every tie; port 1 only after m0 drops
    tick();
    sel = 1;
    contend(4, 3, seq, n0, n1);
    chk("fp_sequence", seq, 32'h1112);
    tick();
    sel = 0;

    // Stalled memory triggers the watchdog
    mem_en = 1'b0;
    tick();
    m0_addr = 8'h10; m0_we = 1'b0; m0_req = 1'b1;
    acc = 0; errs = 0; got = 0;
    for (int c = 0; c < 64 && !got; c++) begin
      tick();
      if (mem_req_w[0]) acc++;
      if (err_w[0]) errs++;
      if (m0_ready_w[0]) begin
        got = 1;
        chk("to_err_with_ready", err_w[0], 1);
        chk("to_rdata", m0_rdata_w[0], 8'hFF);
      end
    end
    m0_req = 1'b0;
    chk("to_ready_seen", got, 1);
    chk("to_access_cycles", acc, TIMEOUT);
    chk("to_err_pulses", errs, 1);
    tick();
    mem_en = 1'b1;
    chk("to_idle_grant", grant_w[0], 0);
    chk("to_err_cleared", err_w[0], 0);

    // Reset in the middle of an access
    m1_addr = 8'h04; m1_we = 1'b0; m1_req = 1'b1;
    tick();
    chk("rst_in_access", mem_req_w[0], 1);
    rst = 1'b1;
    tick();
    chk("rst_mem_req", mem_req_w[0], 0);
    chk("rst_grant", grant_w[0], 0);
    chk("rst_no_ready", m1_ready_w[0], 0);
    m0_addr = 8'h04; m0_req = 1'b1;
    tick();
    chk("rst_hold_no_ready", m1_ready_w[0] | m0_ready_w[0], 0);
    rst = 1'b0;
    tick();
    chk("rst_first_tie_port0", grant_w[0], 2'b01);
    got = 0;
    for (int c = 0; c < 16 && !got; c++) begin
      tick();
      if (m0_ready_w[0]) got = 1;
    end
    m0_req = 1'b0; m1_req = 1'b0;
    chk("rst_tie_completes", got, 1);

    repeat (8) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", checks);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single 256-byte unified memory between two requesters using the eightbit CPU's req/ready handshake.
  - Port 0 is the CPU.
  - Port 1 is a secondary master, such as the program loader or debug/DMA engine.
- Serializes requests, routes address, write-enable and data to the memory, and returns read data plus a one-cycle ready pulse to the granted master.
- Includes a watchdog so a stalled memory cannot hang the CPU.

Parameters:
- AW, 8, address width.
- DW, 8, data width.
- TIMEOUT, 16, maximum ACCESS cycles waiting for mem_ready before abort (>=2).
- FIXED_PRIO, 0, 0 = round-robin; 1 = port 0 always wins ties.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- m0_req  in  1  port 0 request; held with addr/we/wdata stable until m0_ready.
- m0_addr  in  AW  port 0 address.
- m0_we  in  1  port 0 write enable (1 = write).
- m0_wdata  in  DW  port 0 write data.
- m0_ready  out  1  one-cycle completion pulse to port 0.
- m0_rdata  out  DW  port 0 read data, valid while m0_ready=1.
- m1_req, m1_addr, m1_we, m1_wdata, m1_ready, m1_rdata: same as port 0, for port 1.
- mem_req  out  1  request to memory.
- mem_addr  out  AW  memory address.
- mem_we  out  1  memory write enable.
- mem_wdata  out  DW  memory write data.
- mem_ready  in  1  memory completion, sampled in ACCESS.
- mem_rdata  in  DW  memory read data, valid with mem_ready.
- grant  out  2  one-hot owner; 00 when idle.
- err  out  1  one-cycle pulse on timeout abort.

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - state=IDLE; grant=00.
  - All mem_* outputs 0; m*_ready=0; m*_rdata=0; err=0.
  - last_grant=1, so port 0 wins the first tie; timeout counter=0.
  - rst mid-transaction aborts immediately; no ready is issued.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - No request: stay in IDLE.
  - Any req=1: register grant and go to ACCESS.
  - Winner selection:
    - Only one requester: that port wins.
    - Both requesting, FIXED_PRIO=1: port 0 wins.
    - Both requesting, FIXED_PRIO=0: the port not equal to last_grant wins.
  - Set last_grant to the winner; clear the timeout counter.
- ACCESS:
  - mem_req=1; mem_addr/mem_we/mem_wdata are combinationally muxed from the granted port.
  - mem_ready=1: capture mem_rdata into the granted port's rdata register and go to DONE.
  - Otherwise increment the counter.
    - When the counter reaches TIMEOUT-1 without mem_ready: go to DONE with rdata forced to all-ones and err pulsed in DONE.
  - Requests from the other port are ignored; they are not queued and not lost, because the requester keeps holding req.
- DONE:
  - Granted port's m*_ready=1 for exactly one cycle; mem_req=0.
  - Next state is IDLE; grant returns to 00 in IDLE.
- m*_rdata:
  - Holds its last value until the next completion on that port.
  - Writes update m*_rdata with mem_rdata as returned by memory; masters ignore it on writes.
- Latency with single-cycle memory (mem_ready one cycle after mem_req): req seen in IDLE at cycle N, mem_req in N+1, mem_ready sampled at end of N+2, m*_ready in N+3. Uncontended access is 4 cycles including the return to IDLE.
- A req still high in the IDLE cycle after DONE is a new transaction.
  - The master must deassert req in the cycle after ready to avoid a duplicate access.
- Back-to-back contention (round-robin): alternates 0,1,0,1. Neither port waits more than one foreign transaction.
- mem_req never asserts outside ACCESS.
- grant is one-hot or zero at all times.

Test Plan:
- Reset, then m0 read addr 0x04, memory holds 0x20, mem_ready one cycle after mem_req -> mem_addr=0x04, m0_ready single pulse 3 cycles after req, m0_rdata=0x20, grant=01 then 00.
- m1 write 0xE0<=0x55 -> mem_we=1, mem_wdata=0x55 during ACCESS. A following m1 read of 0xE0 returns 0x55; m0_ready stays 0 throughout.
- m0 and m1 assert req in the same cycle, both held continuously for 6 transactions, FIXED_PRIO=0 -> grant sequence 01,10,01,10,01,10; each port sees 3 ready pulses.
- Same contention with FIXED_PRIO=1 -> port 0 served on every tie; m1 served only while m0_req=0.
- mem_ready held 0, TIMEOUT=16 -> exactly 16 ACCESS cycles, then err pulse and m0_ready pulse with m0_rdata=0xFF, then IDLE.
- rst asserted during ACCESS -> next cycle mem_req=0, grant=00, no m*_ready. After release, first tie goes to port 0.
